// File: rtl/syn_fifo_pkg.sv
// Shared definitions for the synchronous threshold FIFO: output mode encodings
// and the depth helper used to size storage from the pointer width.
package syn_fifo_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_depth(input int addr_width);
    return 2 ** addr_width;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port FIFO storage: synchronous write, asynchronous read, contents never reset.
module fifo_mem_2p
  import syn_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int FIFO_DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/syn_fifo_thr.sv
// Single-clock FIFO with exact occupancy, almost-full/empty thresholds, sticky
// overflow/underflow flags and a choice of registered or fall-through read data.
module syn_fifo_thr
  import syn_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  is_empty,
  output logic                  is_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   data_avail,
  output logic [ADDR_WIDTH:0]   room_avail,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int FIFO_DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH:0]   w_ptr;
  logic [ADDR_WIDTH:0]   r_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Every flag is a pure decode of the registered count, so none lags an operation.
  assign is_empty     = (count == '0);
  assign is_full      = (count == DEPTH_CNT);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);
  assign data_avail   = count;
  assign room_avail   = DEPTH_CNT - count;

  assign wr_acc = w_en & ~is_full;
  assign rd_acc = r_en & ~is_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_acc) begin
        w_ptr <= w_ptr + ONE;
      end
      if (rd_acc) begin
        r_ptr <= r_ptr + ONE;
      end
      if (wr_acc && !rd_acc) begin
        count <= count + ONE;
      end else if (rd_acc && !wr_acc) begin
        count <= count - ONE;
      end
    end
  end

  // A new error in the same cycle as clr_err must survive the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && is_full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (r_en && is_empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  // The wrap-bit pointers and the counter are redundant views of occupancy.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ((w_ptr - r_ptr) == count);
    end
  end

  fifo_mem_2p #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(w_ptr[ADDR_WIDTH-1:0]),
    .wdata(w_data),
    .raddr(r_ptr[ADDR_WIDTH-1:0]),
    .rdata(mem_rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign r_data  = mem_rdata;
    assign r_valid = ~is_empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] r_data_q;
    logic                  r_valid_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else begin
        r_valid_q <= rd_acc;
        if (rd_acc) begin
          r_data_q <= mem_rdata;
        end
      end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
  end

endmodule

// File: tb/tb_syn_fifo_thr.sv
// Drives a registered-read and a fall-through FIFO with the same directed vectors and
// checks both every cycle against a queue model, plus hand-computed spot values.
module tb_syn_fifo_thr;
  import syn_fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic       clk = 1'b0;
  logic       rst_n, w_en, r_en, clr_err;
  logic [7:0] w_data;

  logic [7:0] r_data0, r_data1;
  logic       r_valid0, r_valid1, is_empty0, is_empty1, is_full0, is_full1;
  logic       almost_full0, almost_full1, almost_empty0, almost_empty1;
  logic [4:0] data_avail0, data_avail1, room_avail0, room_avail1;
  logic       overflow0, overflow1, underflow0, underflow1;

  int compared   = 0;
  int mismatched = 0;
  bit checking   = 1'b0;

  logic [7:0] m_q[$];
  logic       m_ovf, m_unf, m_rv;
  logic [7:0] m_rd;

  always #5 clk = ~clk;

  syn_fifo_thr #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(FIFO_MODE_REG),
                 .AF_LEVEL(AF), .AE_LEVEL(AE)) dut0 (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .r_data(r_data0), .r_valid(r_valid0), .is_empty(is_empty0), .is_full(is_full0),
    .almost_full(almost_full0), .almost_empty(almost_empty0),
    .data_avail(data_avail0), .room_avail(room_avail0),
    .overflow(overflow0), .underflow(underflow0), .clr_err(clr_err)
  );

  syn_fifo_thr #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(FIFO_MODE_FWFT),
                 .AF_LEVEL(AF), .AE_LEVEL(AE)) dut1 (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .r_data(r_data1), .r_valid(r_valid1), .is_empty(is_empty1), .is_full(is_full1),
    .almost_full(almost_full1), .almost_empty(almost_empty1),
    .data_avail(data_avail1), .room_avail(room_avail1),
    .overflow(overflow1), .underflow(underflow1), .clr_err(clr_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r,
                               input logic c);
    w_en    = w;
    w_data  = d;
    r_en    = r;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  // Queue model: a read pops the head, a write appends, both judged on pre-edge occupancy.
  always @(posedge clk) begin
    automatic bit was_full  = (m_q.size() == DEPTH);
    automatic bit was_empty = (m_q.size() == 0);
    if (!rst_n) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
      m_rd  = 8'h00;
    end else begin
      m_rv = 1'b0;
      if (r_en && !was_empty) begin
        m_rd = m_q.pop_front();
        m_rv = 1'b1;
      end
      if (w_en && !was_full) m_q.push_back(w_data);
      if (w_en && was_full) m_ovf = 1'b1;
      else if (clr_err) m_ovf = 1'b0;
      if (r_en && was_empty) m_unf = 1'b1;
      else if (clr_err) m_unf = 1'b0;
    end
  end

  always @(negedge clk) begin
    automatic int n = m_q.size();
    if (checking) begin
      checkOutput("data_avail", data_avail0, n);
      checkOutput("room_avail", room_avail0, DEPTH - n);
      checkOutput("is_empty", is_empty0, n == 0);
      checkOutput("is_full", is_full0, n == DEPTH);
      checkOutput("almost_full", almost_full0, n >= AF);
      checkOutput("almost_empty", almost_empty0, n <= AE);
      checkOutput("overflow", overflow0, m_ovf);
      checkOutput("underflow", underflow0, m_unf);
      checkOutput("r_valid_reg", r_valid0, m_rv);
      checkOutput("r_data_reg", r_data0, m_rd);
      checkOutput("full_and_empty", is_full0 & is_empty0, 0);
      checkOutput("fwft_data_avail", data_avail1, n);
      checkOutput("fwft_is_full", is_full1, n == DEPTH);
      checkOutput("fwft_overflow", overflow1, m_ovf);
      checkOutput("fwft_underflow", underflow1, m_unf);
      checkOutput("fwft_r_valid", r_valid1, n > 0);
      if (n > 0) checkOutput("fwft_r_data", r_data1, m_q[0]);
    end
  end

  initial begin
    rst_n   = 1'b0;
    w_en    = 1'b0;
    r_en    = 1'b0;
    clr_err = 1'b0;
    w_data  = 8'h00;
    @(posedge clk);
    #1;
    applyStimulus(0, 8'h00, 0, 0);
    rst_n    = 1'b1;
    checking = 1'b1;

    $display("[TB] reset and idle");
    repeat (3) applyStimulus(0, 8'h00, 0, 0);
    checkOutput("rst_is_empty", is_empty0, 1);
    checkOutput("rst_almost_empty", almost_empty0, 1);
    checkOutput("rst_data_avail", data_avail0, 0);
    checkOutput("rst_room_avail", room_avail0, 16);
    checkOutput("rst_overflow", overflow0, 0);
    checkOutput("rst_underflow", underflow0, 0);
    checkOutput("rst_r_valid", r_valid0, 0);
    checkOutput("rst_fwft_r_valid", r_valid1, 0);

    $display("[TB] fill");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 8'(i), 0, 0);
      if (i == 10) checkOutput("af_after_11", almost_full0, 0);
      if (i == 11) checkOutput("af_after_12", almost_full0, 1);
    end
    checkOutput("full_after_16", is_full0, 1);
    checkOutput("room_after_16", room_avail0, 0);
    applyStimulus(1, 8'hEE, 0, 0);
    checkOutput("ovf_after_17", overflow0, 1);
    checkOutput("count_after_17", data_avail0, 16);
    checkOutput("fwft_head_full", r_data1, 8'h00);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("ovf_cleared", overflow0, 0);

    $display("[TB] drain");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 8'h00, 1, 0);
      checkOutput("drain_valid", r_valid0, 1);
      checkOutput("drain_data", r_data0, 8'(i));
    end
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("unf_after_17", underflow0, 1);
    checkOutput("no_valid_17", r_valid0, 0);
    checkOutput("data_held", r_data0, 8'h0F);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("unf_cleared", underflow0, 0);

    $display("[TB] simultaneous read and write");
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'(8'h10 + i), 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 8'(8'h20 + k), 1, 0);
      checkOutput("rw_count", data_avail0, 5);
      checkOutput("rw_order", r_data0, 8'(8'h10 + k));
    end
    for (int i = 0; i < 11; i++) applyStimulus(1, 8'(8'h30 + i), 0, 0);
    checkOutput("rw_full", is_full0, 1);
    applyStimulus(1, 8'h55, 1, 0);
    checkOutput("rw_full_count", data_avail0, 15);
    checkOutput("rw_full_ovf", overflow0, 1);
    checkOutput("rw_full_data", r_data0, 8'h14);
    applyStimulus(0, 8'h00, 0, 1);
    for (int i = 0; i < 15; i++) applyStimulus(0, 8'h00, 1, 0);
    checkOutput("rw_drained", data_avail0, 0);
    applyStimulus(1, 8'h66, 1, 0);
    checkOutput("rw_empty_count", data_avail0, 1);
    checkOutput("rw_empty_unf", underflow0, 1);
    checkOutput("rw_empty_fwft", r_data1, 8'h66);
    applyStimulus(0, 8'h00, 0, 1);
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("rw_empty_read", r_data0, 8'h66);

    $display("[TB] wrap");
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 16; i++) applyStimulus(1, 8'(8'h80 + round * 16 + i), 0, 0);
      for (int i = 0; i < 16; i++) begin
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("wrap_data", r_data0, 8'(8'h80 + round * 16 + i));
      end
    end

    $display("[TB] fall-through and mid-operation reset");
    applyStimulus(1, 8'hA5, 0, 0);
    checkOutput("fwft_first_data", r_data1, 8'hA5);
    checkOutput("fwft_first_valid", r_valid1, 1);
    checkOutput("reg_no_valid", r_valid0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 8'(8'hB0 + i), 0, 0);
    checkOutput("fwft_seven", data_avail1, 7);
    rst_n = 1'b0;
    applyStimulus(0, 8'h00, 0, 0);
    rst_n = 1'b1;
    checkOutput("midrst_fwft_count", data_avail1, 0);
    checkOutput("midrst_fwft_valid", r_valid1, 0);
    checkOutput("midrst_reg_count", data_avail0, 0);
    checkOutput("midrst_reg_valid", r_valid0, 0);
    checkOutput("midrst_reg_data", r_data0, 8'h00);
    repeat (2) applyStimulus(0, 8'h00, 0, 0);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/syn_fifo_thr.md
Name: syn_fifo_thr

Overview:
Parametrised synchronous single-clock FIFO. Next generation of the core's existing FIFO, adding:
- guarded writes and reads
- exact occupancy counters
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- selectable output mode: registered read, or first-word-fall-through (FWFT)

It buffers data between the 8051 core and its peripherals (UART TX/RX, SFR bus bridges).

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 4, pointer width; depth FIFO_DEPTH = 2**ADDR_WIDTH (localparam, not overridable)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal range 1..FIFO_DEPTH
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL; legal range 0..FIFO_DEPTH-1

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
w_en  in  1  write request
w_data  in  DATA_WIDTH  write data
r_en  in  1  read request
r_data  out  DATA_WIDTH  read data
r_valid  out  1  r_data valid qualifier
is_empty  out  1  count == 0
is_full  out  1  count == FIFO_DEPTH
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
data_avail  out  ADDR_WIDTH+1  words stored (count)
room_avail  out  ADDR_WIDTH+1  FIFO_DEPTH - count
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  clears overflow and underflow

Behaviour:
- Reset (rst_n=0 at posedge), values on the following cycle:
  - w_ptr = r_ptr = 0, count = 0
  - is_empty = 1, is_full = 0, almost_empty = 1, almost_full = 0
  - data_avail = 0, room_avail = FIFO_DEPTH
  - overflow = underflow = 0, r_valid = 0, r_data = 0 (FWFT=0)
  - Memory contents are not cleared.
  - Mid-operation reset discards all stored words; no partial read is completed.
- Pointers are ADDR_WIDTH+1 bits. The low bits address memory; the MSB is the wrap bit. Pointers wrap naturally modulo 2*FIFO_DEPTH.
- Accepted write: wr_acc = w_en & !is_full. Accepted read: rd_acc = r_en & !is_empty. Both are evaluated against the current registered flags.
- Only accepted operations move pointers or the memory. Rejected operations have no side effects except the error flags.
- count is a registered counter, next value:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged on both or neither
- All flags and data_avail/room_avail derive from the registered count. They reflect an accepted operation in the cycle after it, with no extra lag.
- Simultaneous w_en & r_en:
  - not empty and not full: both accepted, count unchanged
  - full: read accepted, write rejected, overflow set
  - empty: write accepted, read rejected, underflow set
- overflow sets on w_en & is_full; underflow sets on r_en & is_empty.
  - Both hold until clr_err.
  - If set and clear occur in the same cycle, set wins.
- FWFT=0 (registered read):
  - On rd_acc, r_data <= mem[r_ptr] and r_valid = 1 in the next cycle.
  - r_valid is a one-cycle pulse per accepted read.
  - r_data holds its last value otherwise.
- FWFT=1 (first-word-fall-through):
  - r_data = mem[r_ptr] combinationally; r_valid = !is_empty.
  - A word written into an empty FIFO at edge N appears on r_data with r_valid=1 after edge N.
  - rd_acc pops the head; the next word appears after the same edge.
- Read-during-write to the same address cannot occur on a live word: write targets w_ptr, which is never an unread location when not full.
- Thresholds: almost_full and almost_empty may both be asserted when the parameter ranges overlap. This is legal and not checked.

Decomposition:
- Shared package syn_fifo_pkg holds:
  - localparam helper FIFO_DEPTH = 2**ADDR_WIDTH
  - the FWFT mode encodings (FIFO_MODE_REG=0, FIFO_MODE_FWFT=1)
- One sub-module fifo_mem_2p: DATA_WIDTH x FIFO_DEPTH storage with a synchronous write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata). No reset.
- syn_fifo_thr contains pointers, counter, flags, error logic and the FWFT=0 output register.

Test Plan:
1. Reset, then idle 3 cycles -> is_empty=1, almost_empty=1, data_avail=0, room_avail=16, overflow=underflow=0, r_valid=0.
2. Fill: 16 writes of 0x00..0x0F, then one extra write -> almost_full rises the cycle after the 12th write; is_full=1 and room_avail=0 after the 16th; the 17th write is dropped and overflow=1; clr_err -> overflow=0.
3. Drain with FWFT=0: 16 reads -> r_valid pulses one cycle after each r_en with r_data 0x00..0x0F in order; a 17th read sets underflow=1 and gives no r_valid pulse.
4. Simultaneous: with count=5, assert w_en & r_en for 4 cycles -> data_avail stays 5 and output order is preserved; when full, w_en & r_en -> count becomes 15 and overflow=1; when empty, w_en & r_en -> count becomes 1 and underflow=1.
5. Wrap: 3 cycles of fill 16 / drain 16 -> data order correct across pointer MSB toggles, and is_full/is_empty are never both 1.
6. FWFT=1: write 0xA5 into empty FIFO -> r_data=0xA5 and r_valid=1 on the next cycle with no r_en; assert rst_n=0 with 7 words stored -> after reset data_avail=0 and r_valid=0.
